// File: rtl/exposure_pkg.sv
// Shared types for the exposure/readout sequencer: FSM states and readout slot phases.
// Pure declarations, no timing or flow control of its own.
package exposure_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPOSE  = 2'd1,
    READOUT = 2'd2
  } state_e;

  localparam int SLOT_LEN = 4;

  // Each row gets a fixed slot: select, convert, settle, release.
  localparam logic [1:0] PH_NRE  = 2'd0;
  localparam logic [1:0] PH_ADC  = 2'd1;
  localparam logic [1:0] PH_HOLD = 2'd2;
  localparam logic [1:0] PH_GAP  = 2'(SLOT_LEN - 1);

endpackage

// File: rtl/exposure_ctrl_multi_if.sv
// Control/pixel-array bundle of the exposure sequencer; slave is the sequencer side.
// Level signals only, no handshake or backpressure.
interface exposure_ctrl_multi_if #(
  parameter int N_ROWS = 2,
  parameter int EXP_W  = 5
);
  logic              init;
  logic              exp_increase;
  logic              exp_decrease;
  logic              erase;
  logic              expose;
  logic [N_ROWS-1:0] nre;
  logic              adc;
  logic              busy;
  logic [EXP_W-1:0]  exp_time;

  modport master (
    output init, exp_increase, exp_decrease,
    input  erase, expose, nre, adc, busy, exp_time
  );

  modport slave (
    input  init, exp_increase, exp_decrease,
    output erase, expose, nre, adc, busy, exp_time
  );
endinterface

// File: rtl/exp_time_reg.sv
// Saturating up/down exposure register; new value visible one cycle after the request.
// No backpressure; adjust requests are dropped while en is low.
module exp_time_reg #(
  parameter int W   = 5,
  parameter int MIN = 2,
  parameter int MAX = 30,
  parameter int DEF = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] val_d,
  output logic [W-1:0] val_q
);

  localparam logic [W-1:0] MIN_V = W'(MIN);
  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] DEF_V = W'(DEF);

  // Simultaneous inc and dec cancel out and hold the value.
  always_comb begin
    val_d = val_q;
    if (en && inc && !dec) begin
      val_d = (val_q >= MAX_V) ? MAX_V : val_q + W'(1);
    end else if (en && dec && !inc) begin
      val_d = (val_q <= MIN_V) ? MIN_V : val_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= DEF_V;
    end else begin
      val_q <= val_d;
    end
  end

endmodule

// File: rtl/exposure_ctrl_multi.sv
// Exposure/readout sequencer: erase while idle, expose exp_time*PRESCALE cycles, 4-cycle slot per row.
// All outputs registered, one cycle after the causing edge; no backpressure, init ignored while busy.
module exposure_ctrl_multi
  import exposure_pkg::*;
#(
  parameter int N_ROWS   = 2,
  parameter int EXP_W    = 5,
  parameter int EXP_MIN  = 2,
  parameter int EXP_MAX  = 30,
  parameter int EXP_DEF  = 2,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  RESET,
  exposure_ctrl_multi_if.slave  bus
);

  localparam int CNT_W = $clog2(EXP_MAX * PRESCALE + 1);
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [1:0]         phase_q, phase_d;
  logic               erase_q, erase_d;
  logic               expose_q, expose_d;
  logic               adc_q, adc_d;
  logic               busy_q, busy_d;
  logic [N_ROWS-1:0]  nre_q, nre_d;
  logic [EXP_W-1:0]   exp_time_q, exp_time_d;
  logic               in_idle;

  assign in_idle = (state_q == IDLE);

  exp_time_reg #(
    .W   (EXP_W),
    .MIN (EXP_MIN),
    .MAX (EXP_MAX),
    .DEF (EXP_DEF)
  ) u_exp_time_reg (
    .clk   (clk),
    .rst   (RESET),
    .en    (in_idle),
    .inc   (bus.exp_increase),
    .dec   (bus.exp_decrease),
    .val_d (exp_time_d),
    .val_q (exp_time_q)
  );

  // Load from exp_time_d so an adjust in the init cycle applies to this frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (bus.init) begin
          state_d = EXPOSE;
          cnt_d   = CNT_W'(exp_time_d) * CNT_W'(PRESCALE);
        end
      end
      EXPOSE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = READOUT;
          cnt_d   = '0;
          row_d   = '0;
          phase_d = PH_NRE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READOUT: begin
        if (phase_q == PH_GAP) begin
          phase_d = PH_NRE;
          if (row_q == LAST_ROW) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so they line up with it once registered.
  always_comb begin
    erase_d  = (state_d == IDLE);
    expose_d = (state_d == EXPOSE);
    busy_d   = (state_d != IDLE);
    adc_d    = (state_d == READOUT) && (phase_d == PH_ADC);
    nre_d    = '1;
    if ((state_d == READOUT) && (phase_d != PH_GAP)) begin
      for (int r = 0; r < N_ROWS; r++) begin
        if (row_d == ROW_W'(r)) begin
          nre_d[r] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      phase_q  <= PH_NRE;
      erase_q  <= 1'b1;
      expose_q <= 1'b0;
      adc_q    <= 1'b0;
      busy_q   <= 1'b0;
      nre_q    <= '1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      phase_q  <= phase_d;
      erase_q  <= erase_d;
      expose_q <= expose_d;
      adc_q    <= adc_d;
      busy_q   <= busy_d;
      nre_q    <= nre_d;
    end
  end

  assign bus.erase    = erase_q;
  assign bus.expose   = expose_q;
  assign bus.adc      = adc_q;
  assign bus.busy     = busy_q;
  assign bus.nre      = nre_q;
  assign bus.exp_time = exp_time_q;

endmodule

// File: tb/tb_exposure_ctrl_multi.sv
// Bench for exposure_ctrl_multi: a 2-row/PRESCALE=1 instance and a 4-row/PRESCALE=4 instance.
// Per-cycle expected output words are queued at stimulus time and popped on each falling edge.
module tb_exposure_ctrl_multi;

  logic clk;
  logic RESET;

  exposure_ctrl_multi_if #(.N_ROWS(2), .EXP_W(5)) ifa ();
  exposure_ctrl_multi_if #(.N_ROWS(4), .EXP_W(5)) ifb ();

  exposure_ctrl_multi #(
    .N_ROWS(2), .EXP_W(5), .EXP_MIN(2), .EXP_MAX(30), .EXP_DEF(2), .PRESCALE(1)
  ) u_dut_a (
    .clk   (clk),
    .RESET (RESET),
    .bus   (ifa)
  );

  exposure_ctrl_multi #(
    .N_ROWS(4), .EXP_W(5), .EXP_MIN(2), .EXP_MAX(30), .EXP_DEF(2), .PRESCALE(4)
  ) u_dut_b (
    .clk   (clk),
    .RESET (RESET),
    .bus   (ifb)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Output word: {erase, expose, adc, busy, nre[3:0]} with unused rows padded high.
  function automatic logic [7:0] ent(input logic er, input logic ex, input logic ad,
                                     input logic bu, input logic [3:0] n);
    return {er, ex, ad, bu, n};
  endfunction

  localparam logic [7:0] IDLE_E = 8'b1000_1111;

  function automatic logic [7:0] obs_a();
    return {ifa.erase, ifa.expose, ifa.adc, ifa.busy, 2'b11, ifa.nre};
  endfunction

  function automatic logic [7:0] obs_b();
    return {ifb.erase, ifb.expose, ifb.adc, ifb.busy, ifb.nre};
  endfunction

  task automatic push_frame(input int dut, input int e, input int nr, input bit lead);
    logic [7:0] s[$];
    logic [3:0] n;
    if (lead) s.push_back(IDLE_E);
    for (int i = 0; i < e; i++) s.push_back(ent(1'b0, 1'b1, 1'b0, 1'b1, 4'hF));
    for (int r = 0; r < nr; r++) begin
      for (int p = 0; p < 4; p++) begin
        n = 4'hF;
        if (p != 3) n[r] = 1'b0;
        s.push_back(ent(1'b0, 1'b0, (p == 1), 1'b1, n));
      end
    end
    s.push_back(IDLE_E);
    foreach (s[k]) begin
      if (dut == 0) qa.push_back(s[k]);
      else          qb.push_back(s[k]);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check_eq("frame_a", obs_a(), e);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check_eq("frame_b", obs_b(), e);
    end
  end

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && (qa.size() + qb.size()) > 0; i++) @(posedge clk);
    #1;
    check_eq("drain", qa.size() + qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    ifa.init = 1'b0; ifa.exp_increase = 1'b0; ifa.exp_decrease = 1'b0;
    ifb.init = 1'b0; ifb.exp_increase = 1'b0; ifb.exp_decrease = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a", obs_a(), IDLE_E);
    check_eq("rst_exp_a", ifa.exp_time, 2);
    check_eq("rst_b", obs_b(), IDLE_E);
    RESET = 1'b0;

    // Default frame: 2 expose cycles, 8 readout cycles, then idle.
    @(posedge clk); #1;
    ifa.init = 1'b1;
    push_frame(0, 2, 2, 1'b1);
    @(posedge clk); #1;
    ifa.init = 1'b0;
    wait_drain(40);

    // Saturation at both ends and hold on both-high.
    ifa.exp_increase = 1'b1;
    repeat (40) @(posedge clk);
    #1 ifa.exp_increase = 1'b0;
    check_eq("sat_max", ifa.exp_time, 30);
    ifa.exp_decrease = 1'b1;
    repeat (40) @(posedge clk);
    #1 ifa.exp_decrease = 1'b0;
    check_eq("sat_min", ifa.exp_time, 2);
    ifa.exp_increase = 1'b1;
    @(posedge clk); #1;
    ifa.exp_increase = 1'b0;
    check_eq("inc_one", ifa.exp_time, 3);
    ifa.exp_increase = 1'b1; ifa.exp_decrease = 1'b1;
    repeat (5) @(posedge clk);
    #1 ifa.exp_increase = 1'b0; ifa.exp_decrease = 1'b0;
    check_eq("both_hold", ifa.exp_time, 3);
    ifa.exp_decrease = 1'b1;
    @(posedge clk); #1;
    ifa.exp_decrease = 1'b0;
    check_eq("dec_one", ifa.exp_time, 2);

    // Adjust and init are ignored while busy.
    @(posedge clk); #1;
    ifa.init = 1'b1;
    push_frame(0, 2, 2, 1'b1);
    @(posedge clk); #1;
    ifa.init = 1'b0; ifa.exp_increase = 1'b1;
    repeat (4) @(posedge clk);
    #1 ifa.init = 1'b1;
    @(posedge clk); #1;
    ifa.init = 1'b0;
    repeat (4) @(posedge clk);
    #1 ifa.exp_increase = 1'b0;
    wait_drain(20);
    check_eq("blocked_exp", ifa.exp_time, 2);
    for (int i = 0; i < 4; i++) begin
      check_eq("no_extra_frame", obs_a(), IDLE_E);
      @(posedge clk); #1;
    end

    // Scaled instance: increase in the init cycle gives exp_time=3 -> 12 expose cycles.
    ifb.init = 1'b1; ifb.exp_increase = 1'b1;
    push_frame(1, 12, 4, 1'b1);
    @(posedge clk); #1;
    ifb.init = 1'b0; ifb.exp_increase = 1'b0;
    wait_drain(60);
    check_eq("scale_exp_b", ifb.exp_time, 3);

    // init held: two frames with one idle cycle between.
    @(posedge clk); #1;
    ifa.init = 1'b1;
    push_frame(0, 2, 2, 1'b1);
    push_frame(0, 2, 2, 1'b0);
    repeat (12) @(posedge clk);
    #1 ifa.init = 1'b0;
    wait_drain(40);

    // Reset mid-readout restores idle outputs and default exposure.
    ifa.exp_increase = 1'b1;
    @(posedge clk); #1;
    ifa.exp_increase = 1'b0;
    check_eq("pre_rst_exp", ifa.exp_time, 3);
    ifa.init = 1'b1;
    @(posedge clk); #1;
    ifa.init = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", ifa.busy, 1);
    RESET = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_out", obs_a(), IDLE_E);
    check_eq("mid_rst_exp", ifa.exp_time, 2);
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_eq("post_rst_idle", obs_a(), IDLE_E);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
